rom_access_arbiter: RTL
=======================

// Module: rom_access_arbiter
// PURPOSE
//   Shares one synchronous credential ROM port (user-ID or password table) between two
//   requesters: A = ID-checking FSM, B = password-checking FSM.
//   Round-robin arbitration; one access in flight at a time; latency-matched return of ROM
//   data tagged to the owning requester. Sits between the login checkers and the ROM IP.
// PARAMETERS
//   AW       5   ROM address width (32 entries)
//   DW       16  ROM data width (4 BCD digits)
//   ROM_LAT  2   ROM latency: edges from rom_addr change to valid rom_q; legal 1..15
// PORTS
//   clk       in   1   system clock (50 MHz)
//   rst       in   1   reset; asynchronous, active-high
//   req_a     in   1   requester A read request; hold until gnt_a
//   addr_a    in   AW  requester A address; hold with req_a
//   gnt_a     out  1   one-cycle pulse: A's request accepted
//   rvalid_a  out  1   one-cycle pulse: rdata_a valid
//   rdata_a   out  DW  ROM word returned to A; held until next rvalid_a
//   req_b     in   1   requester B read request
//   addr_b    in   AW  requester B address
//   gnt_b     out  1   one-cycle pulse: B's request accepted
//   rvalid_b  out  1   one-cycle pulse: rdata_b valid
//   rdata_b   out  DW  ROM word returned to B
//   rom_addr  out  AW  address driven to ROM
//   rom_q     in   DW  ROM read data
//   busy      out  1   high while an access is in flight (state != IDLE)
// BEHAVIOUR
//   Reset (async, any time): state=IDLE, all outputs 0, rom_addr=0, last-grant ptr = B
//     (so A wins first tie). In-flight access discarded; no rvalid is generated.
//   All outputs registered. FSM states: IDLE, WAIT.
//   IDLE: at an edge where req_a|req_b is sampled high -> accept one requester:
//     only one high -> that one; both high -> the one not granted last; update ptr.
//     Same edge: rom_addr<=addr_x, owner<=x, cnt<=ROM_LAT, gnt_x<=1, state<=WAIT.
//   WAIT: cnt decrements each edge; requests ignored (req must stay high to be served later).
//     At the edge where cnt==0 sampled: rdata_owner<=rom_q, rvalid_owner<=1, state<=IDLE.
//   Timing: accept edge E0 -> gnt high E0..E0+1 -> rvalid high after edge E0+ROM_LAT+1.
//     Request-to-data latency = ROM_LAT+1 cycles (3 at default).
//   Next accept earliest at edge after rvalid edge: back-to-back period ROM_LAT+2 cycles.
//   gnt_x and rvalid_x each high exactly one cycle; gnt_a&gnt_b never both high; same for rvalid.
//   Requester must drop req the cycle after gnt or it is treated as a new request.
//   rdata_x of the non-owner never changes. rom_addr holds its value between accesses.
//   cnt width 4 bits; no wrap (ROM_LAT<=15).
// TESTING
//   T1 rst pulse mid-idle -> all outputs 0, rom_addr=0, busy=0 within same cycle (async).
//   T2 ROM model addr5=16'h9989; req_a addr 5 -> gnt_a 1 cycle, rvalid_a 3 cycles after
//      accept, rdata_a=16'h9989; rvalid_b/rdata_b stay 0.
//   T3 req_a (addr 1) and req_b (addr 2) same edge after reset -> A served first, B accepted
//      edge after rvalid_a, rvalid_b 4 cycles after rvalid_a with rdata_b=ROM[2].
//   T4 req_a, req_b held continuously (re-asserted after each gnt) -> grants alternate
//      A,B,A,B; each rvalid matches owner and address.
//   T5 rst asserted 1 cycle after accept of req_b -> no rvalid_b; after release req_b served
//      normally with correct data and latency.
//   T6 req_b raised while A in WAIT -> no gnt_b until edge after rvalid_a; busy high throughout.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between two requesters.
// One access in flight at a time; returned data is tagged to the requester that owns it.
module rom_access_arbiter #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 16,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          busy
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            owner_b_q, owner_b_d;
    logic            last_b_q, last_b_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic            rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DW-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic            pick_b;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_b_d  = owner_b_q;
        last_b_d   = last_b_q;
        rom_addr_d = rom_addr_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        pick_b     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    // On a tie, serve whichever requester was not granted last.
                    pick_b     = req_b && (!req_a || !last_b_q);
                    last_b_d   = pick_b;
                    owner_b_d  = pick_b;
                    rom_addr_d = pick_b ? addr_b : addr_a;
                    gnt_a_d    = !pick_b;
                    gnt_b_d    = pick_b;
                    cnt_d      = 4'(ROM_LAT);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (owner_b_q) begin
                        rdata_b_d  = rom_q;
                        rvalid_b_d = 1'b1;
                    end else begin
                        rdata_a_d  = rom_q;
                        rvalid_a_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            owner_b_q  <= 1'b0;
            last_b_q   <= 1'b1;
            rom_addr_q <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_b_q  <= owner_b_d;
            last_b_q   <= last_b_d;
            rom_addr_q <= rom_addr_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rom_addr = rom_addr_q;
    assign busy     = (state_q == StWait);

endmodule
